// File: rtl/rf_wr_arbiter_pkg.sv
// rtl/rf_wr_arbiter_pkg.sv - shared parameters and types for the register-file write arbiter
package rf_wr_arbiter_pkg;

  localparam int XLEN       = 32;
  localparam int REG_AW     = 5;
  localparam int FIFO_DEPTH = 2;
  localparam int STARVE_MAX = 3;

  localparam int ADDR_LINE  = REG_AW;
  localparam int D_SIZE     = XLEN;
  localparam int PTR_W      = $clog2(FIFO_DEPTH);
  localparam int LVL_W      = $clog2(FIFO_DEPTH + 1);
  localparam int STARVE_W   = $clog2(STARVE_MAX + 1);

  typedef struct packed {
    logic [ADDR_LINE-1:0] addr;
    logic [D_SIZE-1:0]    data;
  } rf_entry_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_A    = 2'd1,
    GNT_B    = 2'd2
  } grant_e;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

endpackage

// File: rtl/rf_wr_arbiter_if.sv
// rtl/rf_wr_arbiter_if.sv - write-back, long-latency and register-file port bundle
interface rf_wr_arbiter_if;
  import rf_wr_arbiter_pkg::*;

  logic              wb_valid;
  logic [REG_AW-1:0] wb_addr;
  logic [XLEN-1:0]   wb_data;
  logic              wb_stall;
  logic              lu_valid;
  logic [REG_AW-1:0] lu_addr;
  logic [XLEN-1:0]   lu_data;
  logic              lu_ready;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [XLEN-1:0]   rf_wdata;
  logic [LVL_W-1:0]  fifo_level;

  modport master (
    output wb_valid, wb_addr, wb_data, lu_valid, lu_addr, lu_data,
    input  wb_stall, lu_ready, rf_we, rf_waddr, rf_wdata, fifo_level
  );

  modport slave (
    input  wb_valid, wb_addr, wb_data, lu_valid, lu_addr, lu_data,
    output wb_stall, lu_ready, rf_we, rf_waddr, rf_wdata, fifo_level
  );

endinterface

// File: rtl/rf_wr_fifo.sv
// rtl/rf_wr_fifo.sv - small in-order buffer for long-latency results, exposes every entry address
module rf_wr_fifo
  import rf_wr_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  rf_entry_t         push_entry_i,
  input  logic              pop_i,
  output rf_entry_t         head_o,
  output logic [LVL_W-1:0]  level_o,
  output logic [REG_AW-1:0] entry_addr_o [FIFO_DEPTH],
  output logic [FIFO_DEPTH-1:0] entry_valid_o
);

  rf_entry_t        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  always_comb begin
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    level_d  = level_q;
    case ({push_i, pop_i})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

  // An entry is live when its distance from the read pointer is below the level.
  always_comb begin
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      entry_valid_o[i] = {1'b0, PTR_W'(PTR_W'(i) - rd_ptr_q)} < level_q;
      entry_addr_o[i]  = mem_q[i].addr;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;

endmodule

// File: rtl/rf_wr_arbiter.sv
// rtl/rf_wr_arbiter.sv - arbitrates pipeline write-back against buffered long-latency results
module rf_wr_arbiter
  import rf_wr_arbiter_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  rf_wr_arbiter_if.slave bus
);

  rf_entry_t         head;
  logic [LVL_W-1:0]  level;
  logic [REG_AW-1:0] entry_addr [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] entry_valid;

  logic   lu_ready, push, pop;
  logic   b_req, waw_hit, force_b;
  grant_e grant;

  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                rf_we_q, rf_we_d;
  logic [REG_AW-1:0]   rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]     rf_wdata_q, rf_wdata_d;

  // B is masked during reset so the pipeline sees an empty buffer.
  assign lu_ready = rst_n && (level < LVL_W'(FIFO_DEPTH));
  assign b_req    = rst_n && (level != '0);
  assign push     = bus.lu_valid && lu_ready;
  assign pop      = (grant == GNT_B);

  rf_wr_fifo u_fifo (
    .clk           (clk),
    .rst_n         (rst_n),
    .push_i        (push),
    .push_entry_i  ('{addr: bus.lu_addr, data: bus.lu_data}),
    .pop_i         (pop),
    .head_o        (head),
    .level_o       (level),
    .entry_addr_o  (entry_addr),
    .entry_valid_o (entry_valid)
  );

  always_comb begin
    waw_hit = 1'b0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (entry_valid[i] && (entry_addr[i] == bus.wb_addr)) waw_hit = 1'b1;
    end
  end

  assign force_b = (level == LVL_W'(FIFO_DEPTH)) || (starve_q == STARVE_W'(STARVE_MAX)) || waw_hit;

  always_comb begin
    grant = GNT_NONE;
    if (bus.wb_valid && b_req) grant = force_b ? GNT_B : GNT_A;
    else if (bus.wb_valid)     grant = GNT_A;
    else if (b_req)            grant = GNT_B;
  end

  always_comb begin
    starve_d = '0;
    if (b_req && (grant != GNT_B)) begin
      starve_d = (starve_q == STARVE_W'(STARVE_MAX)) ? starve_q : starve_q + 1'b1;
    end
  end

  always_comb begin
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    case (grant)
      GNT_A: begin
        rf_waddr_d = bus.wb_addr;
        rf_wdata_d = bus.wb_data;
      end
      GNT_B: begin
        rf_waddr_d = head.addr;
        rf_wdata_d = head.data;
      end
      default: ;
    endcase
    // r0 is hardwired: the request is consumed but never written.
    rf_we_d = (grant != GNT_NONE) && (rf_waddr_d != '0);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      starve_q   <= starve_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign bus.wb_stall   = bus.wb_valid && (grant != GNT_A);
  assign bus.lu_ready   = lu_ready;
  assign bus.rf_we      = rf_we_q;
  assign bus.rf_waddr   = rf_waddr_q;
  assign bus.rf_wdata   = rf_wdata_q;
  assign bus.fifo_level = level;

endmodule

// File: doc/rf_wr_arbiter.md
RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 Parameters SHALL be taken from the shared package: XLEN=32 (data width), REG_AW=5 (register address width), FIFO_DEPTH=2 (long-latency buffer entries), STARVE_MAX=3 (consecutive losses before forced grant).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 wb_valid  in  1  pipeline write-back request.
REQ-005 wb_addr  in  REG_AW  pipeline destination register.
REQ-006 wb_data  in  XLEN  pipeline write data.
REQ-007 wb_stall  out  1  combinational; pipeline WB SHALL hold its request while high.
REQ-008 lu_valid  in  1  long-latency unit result valid.
REQ-009 lu_addr  in  REG_AW  long-latency destination register.
REQ-010 lu_data  in  XLEN  long-latency result data.
REQ-011 lu_ready  out  1  registered-state derived; high when FIFO level < FIFO_DEPTH.
REQ-012 rf_we  out  1  registered register-file write enable.
REQ-013 rf_waddr  out  REG_AW  registered write address.
REQ-014 rf_wdata  out  XLEN  registered write data.
REQ-015 fifo_level  out  2  current FIFO occupancy, 0..2.

Function
REQ-016 Long-latency push SHALL occur when lu_valid && lu_ready; the pushed entry becomes eligible the following cycle (no bypass).
REQ-017 Each cycle the arbiter SHALL select at most one winner: A = wb_valid, B = FIFO head (level > 0).
REQ-018 A alone requesting SHALL win; B alone requesting SHALL win.
REQ-019 Both requesting: B SHALL win if level == 2, or starve_cnt == STARVE_MAX, or wb_addr matches the address of any valid FIFO entry (WAW protection); otherwise A SHALL win.
REQ-020 wb_stall SHALL be high exactly when wb_valid is high and A did not win in that cycle.
REQ-021 A B grant SHALL pop the FIFO head in the same edge; a push and a pop in the same cycle SHALL leave the level unchanged.
REQ-022 starve_cnt SHALL increment (saturating at STARVE_MAX) when B requests and loses, and clear to 0 when B wins or the FIFO is empty.
REQ-023 The winner's address and data SHALL appear on rf_waddr/rf_wdata with rf_we high one cycle after grant (latency 1).
REQ-024 A granted write to address 0 SHALL be consumed normally (pop or stall release) but SHALL drive rf_we low.
REQ-025 Cycles with no winner SHALL drive rf_we low; rf_waddr/rf_wdata SHALL hold their previous values.
REQ-026 FIFO read/write pointers SHALL wrap modulo FIFO_DEPTH; entries SHALL drain in push order.

Reset
REQ-027 While rst_n is low at a clock edge: FIFO level, pointers and starve_cnt SHALL clear to 0; rf_we, rf_waddr and rf_wdata SHALL clear to 0.
REQ-028 Reset asserted mid-operation SHALL discard all buffered entries; no rf_we pulse SHALL occur in the cycle after the reset edge.
REQ-029 During reset, lu_ready SHALL read low; wb_stall SHALL follow REQ-020 with an empty FIFO.

Structure
REQ-030 XLEN, REG_AW, FIFO_DEPTH and STARVE_MAX SHALL be defined in the shared struct package, alongside ADDR_LINE/D_SIZE.
REQ-031 The 2-entry buffer SHALL be a separate sub-module rf_wr_fifo (push, pop, head, level, per-entry address outputs for the WAW compare).
REQ-032 Arbitration, starvation counter and output registers SHALL reside in rf_wr_arbiter.

Verification
REQ-033 WB only: wb_valid=1, wb_addr=5, wb_data=0x1234 for 1 cycle -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234; wb_stall stays 0.
REQ-034 LU fill: push r3=0xA, then r4=0xB with no WB traffic -> lu_ready low when level=2; writes r3 then r4 on consecutive cycles; level returns to 0.
REQ-035 Starvation: FIFO holds one entry (r7), wb_valid held high with distinct addresses -> A wins 3 cycles, 4th cycle B wins, wb_stall=1 for that cycle, r7 written one cycle later.
REQ-036 WAW: FIFO holds r9=0x55, wb_valid with wb_addr=9, data=0x66 -> r9=0x55 written first, then r9=0x66; wb_stall high for exactly one cycle.
REQ-037 r0 and reset: WB write to address 0 -> rf_we stays 0, no stall; then with level=2 assert rst_n=0 for one edge -> level=0, no rf_we pulse afterward, lu_ready high after release.
